// File: rtl/sw_cond_pkg.sv
// Shared constants and helpers for the slide-switch input conditioner.
package sw_cond_pkg;

    // 10 ms hold time at a 100 MHz system clock.
    localparam int unsigned DEFAULT_DEBOUNCE_100MHZ = 32'd1_000_000;

    // Short hold time so benches finish quickly.
    localparam int unsigned SIM_DEBOUNCE = 32'd8;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 32'd0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 32'd1;
        end
        if (r == 32'd0) begin
            r = 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce_channel.sv
// One switch channel: synchroniser chain, hold counter, stable level and
// registered rise/fall strobes. The pre-register strobe values are exported
// so the top level can update its own registers on the same edge.
module sw_debounce_channel
    import sw_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_100MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic stable,
    output logic rise_next,
    output logic fall_next,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_sync;

    assign s_sync = sync_q[SYNC_STAGES-1];

    // Next-state: shift the synchroniser, run the hold counter, derive strobes.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_in};
        cnt_d    = CNT_ZERO;
        stable_d = stable_q;
        prev_d   = stable_q;
        if (s_sync != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = s_sync;
                cnt_d    = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            // Any return to the accepted level restarts qualification.
            cnt_d = CNT_ZERO;
        end
        // Edge detect on the stable level, one cycle behind its update.
        rise_d = stable_q & ~prev_q;
        fall_d = ~stable_q & prev_q;
    end

    // Channel state registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            cnt_q    <= CNT_ZERO;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable    = stable_q;
    assign rise_next = rise_d;
    assign fall_next = fall_d;
    assign rise      = rise_q;
    assign fall      = fall_q;

endmodule

// File: rtl/sw_input_conditioner.sv
// Board switch front end: NUM_SW independent debounce channels plus the
// per-channel toggle latches and a combined any-change strobe.
module sw_input_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned NUM_SW          = 32'd4,
    parameter int unsigned SYNC_STAGES     = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_100MHZ
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_SW-1:0] SW,
    input  logic              TOGGLE_CLR,
    output logic [NUM_SW-1:0] SW_STABLE,
    output logic [NUM_SW-1:0] SW_RISE,
    output logic [NUM_SW-1:0] SW_FALL,
    output logic [NUM_SW-1:0] TOGGLE,
    output logic              SW_CHANGED
);

    logic [NUM_SW-1:0] rise_next_s;
    logic [NUM_SW-1:0] fall_next_s;
    logic [NUM_SW-1:0] toggle_q, toggle_d;
    logic              changed_q, changed_d;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_chan
        sw_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RESET),
            .sw_in     (SW[gi]),
            .stable    (SW_STABLE[gi]),
            .rise_next (rise_next_s[gi]),
            .fall_next (fall_next_s[gi]),
            .rise      (SW_RISE[gi]),
            .fall      (SW_FALL[gi])
        );
    end

    // Toggle on each rise (clear wins) and merge all strobes into one pulse.
    always_comb begin
        toggle_d  = toggle_q;
        changed_d = |(rise_next_s | fall_next_s);
        if (TOGGLE_CLR) begin
            toggle_d = {NUM_SW{1'b0}};
        end else begin
            toggle_d = toggle_q ^ rise_next_s;
        end
    end

    // Toggle latches and change strobe, aligned with the channel strobes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            toggle_q  <= {NUM_SW{1'b0}};
            changed_q <= 1'b0;
        end else begin
            toggle_q  <= toggle_d;
            changed_q <= changed_d;
        end
    end

    assign TOGGLE     = toggle_q;
    assign SW_CHANGED = changed_q;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with a short debounce time.
module tb_sw_input_conditioner;
    import sw_cond_pkg::*;

    logic       CLK;
    logic       RESET;
    logic [3:0] SW;
    logic       TOGGLE_CLR;
    logic [3:0] SW_STABLE;
    logic [3:0] SW_RISE;
    logic [3:0] SW_FALL;
    logic [3:0] TOGGLE;
    logic       SW_CHANGED;

    int vectors;
    int miscompares;

    sw_input_conditioner #(
        .NUM_SW          (32'd4),
        .SYNC_STAGES     (32'd2),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SW         (SW),
        .TOGGLE_CLR (TOGGLE_CLR),
        .SW_STABLE  (SW_STABLE),
        .SW_RISE    (SW_RISE),
        .SW_FALL    (SW_FALL),
        .TOGGLE     (TOGGLE),
        .SW_CHANGED (SW_CHANGED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] st, input logic [3:0] ri,
                              input logic [3:0] fa, input logic [3:0] tg, input logic ch);
        chk($sformatf("%s/stable", tag), SW_STABLE, st);
        chk($sformatf("%s/rise", tag), SW_RISE, ri);
        chk($sformatf("%s/fall", tag), SW_FALL, fa);
        chk($sformatf("%s/toggle", tag), TOGGLE, tg);
        chk($sformatf("%s/changed", tag), {3'b000, SW_CHANGED}, {3'b000, ch});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b1;
        SW          = 4'b0000;
        TOGGLE_CLR  = 1'b0;

        // 1. reset low 10..40 ns, then idle with switches low
        #10 RESET = 1'b0;
        #10 expect_all("rst_t20", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        #10 expect_all("rst_t30", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        #10 RESET = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            expect_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
            tick(1);
        end

        // 2. 0000 -> 1100, accepted on edge 10, strobes on edge 11
        SW = 4'b1100;
        tick(9);
        expect_all("r2_e9", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("r2_e10", 4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("r2_e11", 4'b1100, 4'b1100, 4'b0000, 4'b1100, 1'b1);
        tick(1);
        expect_all("r2_e12", 4'b1100, 4'b0000, 4'b0000, 4'b1100, 1'b0);

        // 3. glitches of 5 and 7 cycles on SW[0] are rejected
        for (int w = 5; w <= 7; w += 2) begin
            SW = 4'b1101;
            tick(w);
            SW = 4'b1100;
            for (int k = 0; k < 14; k++) begin
                tick(1);
                expect_all($sformatf("glitch%0d_%0d", w, k), 4'b1100, 4'b0000, 4'b0000, 4'b1100, 1'b0);
            end
        end

        // 3b. an 8-cycle pulse is accepted, then released again
        SW = 4'b1101;
        tick(8);
        SW = 4'b1100;
        tick(1);
        expect_all("p8_e9", 4'b1100, 4'b0000, 4'b0000, 4'b1100, 1'b0);
        tick(1);
        expect_all("p8_e10", 4'b1101, 4'b0000, 4'b0000, 4'b1100, 1'b0);
        tick(1);
        expect_all("p8_e11", 4'b1101, 4'b0001, 4'b0000, 4'b1101, 1'b1);
        tick(6);
        expect_all("p8_e17", 4'b1101, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        tick(1);
        expect_all("p8_e18", 4'b1100, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        tick(1);
        expect_all("p8_e19", 4'b1100, 4'b0000, 4'b0001, 4'b1101, 1'b1);
        tick(1);
        expect_all("p8_e20", 4'b1100, 4'b0000, 4'b0000, 4'b1101, 1'b0);

        // 4. 1100 -> 0100: fall on SW[3], toggles unchanged
        SW = 4'b0100;
        tick(10);
        expect_all("f4_e10", 4'b0100, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        tick(1);
        expect_all("f4_e11", 4'b0100, 4'b0000, 4'b1000, 4'b1101, 1'b1);
        tick(1);
        expect_all("f4_e12", 4'b0100, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        // second rise on SW[3] returns TOGGLE[3] to 0
        SW = 4'b1100;
        tick(10);
        expect_all("r4_e10", 4'b1100, 4'b0000, 4'b0000, 4'b1101, 1'b0);
        tick(1);
        expect_all("r4_e11", 4'b1100, 4'b1000, 4'b0000, 4'b0101, 1'b1);
        tick(1);
        expect_all("r4_e12", 4'b1100, 4'b0000, 4'b0000, 4'b0101, 1'b0);

        // 5. TOGGLE_CLR on the edge that raises SW_RISE[1]: clear wins
        SW = 4'b1110;
        tick(10);
        expect_all("c5_e10", 4'b1110, 4'b0000, 4'b0000, 4'b0101, 1'b0);
        TOGGLE_CLR = 1'b1;
        tick(1);
        TOGGLE_CLR = 1'b0;
        expect_all("c5_e11", 4'b1110, 4'b0010, 4'b0000, 4'b0000, 1'b1);
        tick(1);
        expect_all("c5_e12", 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // 6. reset mid-count, then full re-qualification of held inputs
        SW = 4'b1111;
        tick(7);
        RESET = 1'b0;
        #1;
        expect_all("rst6_now", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("rst6_h1", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("rst6_h2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        RESET = 1'b1;
        tick(9);
        expect_all("rq6_e9", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("rq6_e10", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        expect_all("rq6_e11", 4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        tick(1);
        expect_all("rq6_e12", 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
